// File: rtl/apb_intercon_rr_pkg.sv
// Shared types and helpers for the round-robin APB interconnect.
package apb_intercon_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Index width that never collapses to zero bits for single-entry ports.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner on each advance pulse.
module apb_rr_arbiter
    import apb_intercon_rr_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = clog2_min1(N)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        int   cand;
        logic found;
        cand        = 0;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o  = IW'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (|req_i)) begin
            ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/apb_intercon_rr.sv
// Multi-master APB interconnect: round-robin master arbitration, address decode
// to one of SLAVE_PORTS slaves, decode-error and PREADY-timeout completions.
//
// state  | meaning
// IDLE   | arbitrate; register granted request and decoded slave index
// SETUP  | PSEL to target slave, PENABLE low (one cycle)
// ACCESS | PSEL+PENABLE; wait for slave ready or timeout
// RESP   | return PREADY/PSLVERR/PRDATA to the granted master
module apb_intercon_rr
    import apb_intercon_rr_pkg::*;
#(
    parameter int MASTER_PORTS = 2,
    parameter int SLAVE_PORTS  = 5,
    parameter int BUS_WIDTH    = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int SLAVE_SHIFT  = 8,
    parameter int TIMEOUT      = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MASTER_PORTS*ADDR_WIDTH-1:0] S_PADDR,
    input  logic [MASTER_PORTS-1:0]            S_PWRITE,
    input  logic [MASTER_PORTS-1:0]            S_PSELx,
    input  logic [MASTER_PORTS-1:0]            S_PENABLE,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PWDATA,
    output logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PRDATA,
    output logic [MASTER_PORTS-1:0]            S_PREADY,
    output logic [MASTER_PORTS-1:0]            S_PSLVERR,
    output logic [ADDR_WIDTH-1:0]              M_PADDR,
    output logic                               M_PWRITE,
    output logic [SLAVE_PORTS-1:0]             M_PSELx,
    output logic                               M_PENABLE,
    output logic [BUS_WIDTH-1:0]               M_PWDATA,
    input  logic [SLAVE_PORTS*BUS_WIDTH-1:0]   M_PRDATA,
    input  logic [SLAVE_PORTS-1:0]             M_PREADY,
    input  logic [SLAVE_PORTS-1:0]             M_PSLVERR
);

    localparam int MW    = clog2_min1(MASTER_PORTS);
    localparam int SW    = clog2_min1(SLAVE_PORTS);
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);

    apb_state_e            state_q, state_d;
    logic [MW-1:0]         gidx_q, gidx_d;
    logic [SW-1:0]         sidx_q, sidx_d;
    logic                  err_q, err_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [SLAVE_PORTS-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;

    logic [MASTER_PORTS-1:0] arb_grant;
    logic [MW-1:0]           arb_idx;
    logic                    arb_advance;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [ADDR_WIDTH-1:0]   sel_full;
    logic                    dec_err;
    logic                    resp_fire;

    apb_rr_arbiter #(.N(MASTER_PORTS)) u_arb (
        .clk_i      (clk),
        .rst_ni     (reset),
        .req_i      (S_PSELx),
        .advance_i  (arb_advance),
        .grant_o    (arb_grant),
        .grant_idx_o(arb_idx)
    );

    // The whole shifted address is compared, so stray high bits decode as errors.
    assign req_addr    = S_PADDR[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_full    = req_addr >> SLAVE_SHIFT;
    assign dec_err     = (sel_full >= ADDR_WIDTH'(SLAVE_PORTS));
    assign arb_advance = (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        sidx_d    = sidx_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_grant) begin
                    gidx_d  = arb_idx;
                    rdata_d = '0;
                    if (dec_err) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d    = 1'b0;
                        sidx_d   = sel_full[SW-1:0];
                        paddr_d  = req_addr;
                        pwrite_d = S_PWRITE[arb_idx];
                        pwdata_d = S_PWDATA[arb_idx*BUS_WIDTH +: BUS_WIDTH];
                        psel_d   = SLAVE_PORTS'(1) << sel_full[SW-1:0];
                        state_d  = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = CW'(TIMEOUT - 1);
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (M_PREADY[sidx_q] || (TO_EN && cnt_q == '0)) begin
                    if (M_PREADY[sidx_q]) begin
                        rdata_d = M_PRDATA[sidx_q*BUS_WIDTH +: BUS_WIDTH];
                        err_d   = M_PSLVERR[sidx_q];
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                    paddr_d   = '0;
                    pwrite_d  = 1'b0;
                    pwdata_d  = '0;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                // Completes on PENABLE; a dropped PSEL retires the transfer silently.
                if (!S_PSELx[gidx_q] || S_PENABLE[gidx_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_fire = (state_q == ST_RESP) && S_PSELx[gidx_q] && S_PENABLE[gidx_q];

    always_comb begin
        S_PREADY  = '0;
        S_PSLVERR = '0;
        S_PRDATA  = '0;
        if (resp_fire) begin
            S_PREADY[gidx_q]  = 1'b1;
            S_PSLVERR[gidx_q] = err_q;
        end
        if (state_q == ST_RESP) S_PRDATA[gidx_q*BUS_WIDTH +: BUS_WIDTH] = rdata_q;
    end

    assign M_PADDR   = paddr_q;
    assign M_PWRITE  = pwrite_q;
    assign M_PWDATA  = pwdata_q;
    assign M_PSELx   = psel_q;
    assign M_PENABLE = penable_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            gidx_q    <= '0;
            sidx_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gidx_q    <= gidx_d;
            sidx_q    <= sidx_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// Directed bench for apb_intercon_rr: two cycle-stepped APB masters and five
// table-driven slaves with configurable wait states, read data and error.
module tb_apb_intercon_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_paddr;
    logic [1:0]  s_pwrite, s_psel, s_penable;
    logic [31:0] s_pwdata;
    logic [31:0] S_PRDATA;
    logic [1:0]  S_PREADY, S_PSLVERR;
    logic [15:0] M_PADDR;
    logic        M_PWRITE;
    logic [4:0]  M_PSELx;
    logic        M_PENABLE;
    logic [15:0] M_PWDATA;
    logic [79:0] m_prdata;
    logic [4:0]  m_pready, m_pslverr;

    apb_intercon_rr dut (
        .clk      (clk),
        .reset    (reset),
        .S_PADDR  (s_paddr),
        .S_PWRITE (s_pwrite),
        .S_PSELx  (s_psel),
        .S_PENABLE(s_penable),
        .S_PWDATA (s_pwdata),
        .S_PRDATA (S_PRDATA),
        .S_PREADY (S_PREADY),
        .S_PSLVERR(S_PSLVERR),
        .M_PADDR  (M_PADDR),
        .M_PWRITE (M_PWRITE),
        .M_PSELx  (M_PSELx),
        .M_PENABLE(M_PENABLE),
        .M_PWDATA (M_PWDATA),
        .M_PRDATA (m_prdata),
        .M_PREADY (m_pready),
        .M_PSLVERR(m_pslverr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Master model state: phase 0 idle, 1 setup, 2 access.
    int          mphase    [2] = '{0, 0};
    int          pend      [2] = '{0, 0};
    logic [15:0] mst_addr  [2] = '{16'h0, 16'h0};
    logic        mst_wr    [2] = '{1'b0, 1'b0};
    logic [15:0] mst_wdata [2] = '{16'h0, 16'h0};
    logic        seen_rdy  [2] = '{1'b0, 1'b0};
    int          start_cyc [2] = '{0, 0};
    int          done_cyc  [2] = '{0, 0};
    logic [15:0] cap_rdata [2] = '{16'h0, 16'h0};
    logic        cap_err   [2] = '{1'b0, 1'b0};
    int          grant_log [$];
    int          spurious  = 0;

    // Slave-side monitor.
    int          sel_cycles, en_cycles, unstable;
    logic [4:0]  sel_or;
    logic        first_en;
    logic [15:0] mon_addr, mon_wdata;
    logic        mon_wr;

    int          slv_wait  [5] = '{0, 0, 0, 0, 0};
    logic [15:0] slv_rdata [5] = '{16'h1000, 16'h2222, 16'h3333, 16'hBEEF, 16'h4444};
    logic        slv_err   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          wcnt = 0;

    always @(posedge clk) begin
        if (M_PENABLE) wcnt <= wcnt + 1;
        else           wcnt <= 0;
    end

    always_comb begin
        m_prdata  = '0;
        m_pready  = '0;
        m_pslverr = '0;
        for (int s = 0; s < 5; s++) begin
            m_prdata[s*16 +: 16] = slv_rdata[s];
            m_pready[s]          = M_PSELx[s] & M_PENABLE & (wcnt >= slv_wait[s]);
            m_pslverr[s]         = slv_err[s];
        end
    end

    always_comb begin
        s_psel    = '0;
        s_penable = '0;
        s_pwrite  = '0;
        s_paddr   = '0;
        s_pwdata  = '0;
        for (int m = 0; m < 2; m++) begin
            s_psel[m]            = (mphase[m] != 0);
            s_penable[m]         = (mphase[m] == 2);
            s_pwrite[m]          = mst_wr[m];
            s_paddr[m*16 +: 16]  = mst_addr[m];
            s_pwdata[m*16 +: 16] = mst_wdata[m];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic mon_clear();
        sel_cycles = 0;
        en_cycles  = 0;
        unstable   = 0;
        sel_or     = '0;
        first_en   = 1'b0;
        mon_addr   = '0;
        mon_wdata  = '0;
        mon_wr     = 1'b0;
    endtask

    // One clock: sample at negedge, advance masters just after posedge.
    task automatic tick();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            if (S_PREADY[m]) begin
                if (mphase[m] == 2 && !seen_rdy[m]) begin
                    seen_rdy[m]  = 1'b1;
                    cap_rdata[m] = S_PRDATA[m*16 +: 16];
                    cap_err[m]   = S_PSLVERR[m];
                    done_cyc[m]  = cyc;
                    grant_log.push_back(m);
                end else begin
                    spurious++;
                end
            end
        end
        if (M_PSELx != '0) begin
            sel_or = sel_or | M_PSELx;
            sel_cycles++;
            if (M_PENABLE) en_cycles++;
            if (sel_cycles == 1) begin
                first_en  = M_PENABLE;
                mon_addr  = M_PADDR;
                mon_wdata = M_PWDATA;
                mon_wr    = M_PWRITE;
            end else if (M_PADDR !== mon_addr || M_PWDATA !== mon_wdata || M_PWRITE !== mon_wr) begin
                unstable++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int m = 0; m < 2; m++) begin
            case (mphase[m])
                1: mphase[m] = 2;
                2: if (seen_rdy[m]) begin
                       seen_rdy[m] = 1'b0;
                       mphase[m]   = 0;
                       pend[m]--;
                   end
                default: if (pend[m] > 0) begin
                       mphase[m]    = 1;
                       start_cyc[m] = cyc;
                   end
            endcase
        end
    endtask

    task automatic issue(input int m, input logic [15:0] addr, input logic wr,
                         input logic [15:0] wdata, input int count);
        mst_addr[m]  = addr;
        mst_wr[m]    = wr;
        mst_wdata[m] = wdata;
        pend[m]      = count;
    endtask

    task automatic run_all(input string tag, input int budget);
        int n;
        n = 0;
        while ((pend[0] > 0 || pend[1] > 0) && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_completed"}, pend[0] + pend[1], 0);
    endtask

    task automatic xfer(input string tag, input int m, input logic [15:0] addr,
                        input logic wr, input logic [15:0] wdata, input int budget);
        mon_clear();
        issue(m, addr, wr, wdata, 1);
        run_all(tag, budget);
    endtask

    initial begin
        reset = 1'b0;
        mon_clear();
        tick();
        tick();
        check_eq("rst_s_outs", {S_PRDATA, S_PREADY, S_PSLVERR}, 0);
        check_eq("rst_m_outs", {M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA}, 0);
        reset = 1'b1;
        tick();

        // Zero-wait read from slave 3.
        xfer("t1", 0, 16'h0310, 1'b0, 16'h0, 20);
        check_eq("t1_latency", done_cyc[0] - start_cyc[0], 3);
        check_eq("t1_rdata", cap_rdata[0], 16'hBEEF);
        check_eq("t1_err", cap_err[0], 0);
        check_eq("t1_paddr", mon_addr, 16'h0310);

        // Write from master 1 to slave 4.
        xfer("t2", 1, 16'h0400, 1'b1, 16'h1234, 20);
        check_eq("t2_psel", sel_or, 5'b10000);
        check_eq("t2_sel_cycles", sel_cycles, 2);
        check_eq("t2_en_cycles", en_cycles, 1);
        check_eq("t2_setup_en", first_en, 0);
        check_eq("t2_pwdata", mon_wdata, 16'h1234);
        check_eq("t2_pwrite", mon_wr, 1);
        check_eq("t2_stable", unstable, 0);
        check_eq("t2_latency", done_cyc[1] - start_cyc[1], 3);

        // Continuous contention: grants must alternate starting with master 0.
        grant_log.delete();
        mon_clear();
        issue(0, 16'h0110, 1'b0, 16'h0, 4);
        issue(1, 16'h0310, 1'b0, 16'h0, 4);
        run_all("t3", 200);
        check_eq("t3_count", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) check_eq($sformatf("t3_grant%0d", i), grant_log[i], i % 2);
        check_eq("t3_m0_rdata", cap_rdata[0], 16'h2222);

        // Decode errors: index out of range, and stray high address bits.
        xfer("t4a", 0, 16'h0700, 1'b0, 16'h0, 20);
        check_eq("t4a_no_psel", sel_or, 0);
        check_eq("t4a_err", cap_err[0], 1);
        check_eq("t4a_rdata", cap_rdata[0], 0);
        xfer("t4b", 1, 16'h0B00, 1'b0, 16'h0, 20);
        check_eq("t4b_no_psel", sel_or, 0);
        check_eq("t4b_err", cap_err[1], 1);

        // Slave-reported error passes through with its data.
        slv_err[0] = 1'b1;
        xfer("t4c", 0, 16'h0005, 1'b0, 16'h0, 20);
        check_eq("t4c_err", cap_err[0], 1);
        check_eq("t4c_rdata", cap_rdata[0], 16'h1000);
        slv_err[0] = 1'b0;

        // Three wait states on slave 1.
        slv_wait[1] = 3;
        xfer("tw", 1, 16'h0120, 1'b0, 16'h0, 30);
        check_eq("tw_latency", done_cyc[1] - start_cyc[1], 6);
        check_eq("tw_en_cycles", en_cycles, 4);
        check_eq("tw_rdata", cap_rdata[1], 16'h2222);

        // Slave 2 never readies: timeout after 64 ACCESS cycles.
        slv_wait[2] = 1000;
        xfer("t5", 0, 16'h0200, 1'b0, 16'h0, 300);
        check_eq("t5_en_cycles", en_cycles, 64);
        check_eq("t5_sel_cycles", sel_cycles, 65);
        check_eq("t5_latency", done_cyc[0] - start_cyc[0], 66);
        check_eq("t5_err", cap_err[0], 1);
        check_eq("t5_rdata", cap_rdata[0], 0);
        xfer("t5_next", 1, 16'h0310, 1'b0, 16'h0, 20);
        check_eq("t5_next_rdata", cap_rdata[1], 16'hBEEF);
        check_eq("t5_next_err", cap_err[1], 0);
        check_eq("t5_next_latency", done_cyc[1] - start_cyc[1], 3);

        // Reset in the middle of a 3-wait access by master 0.
        mon_clear();
        issue(0, 16'h0100, 1'b0, 16'h0, 1);
        for (int i = 0; i < 20 && en_cycles < 2; i++) tick();
        check_eq("t6_in_access", {M_PENABLE, M_PSELx}, 6'b100010);
        reset     = 1'b0;
        mphase[0] = 0;
        pend[0]   = 0;
        #1;
        check_eq("t6_rst_s_outs", {S_PRDATA, S_PREADY, S_PSLVERR}, 0);
        check_eq("t6_rst_m_outs", {M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA}, 0);
        tick();
        tick();
        reset = 1'b1;
        grant_log.delete();
        issue(0, 16'h0310, 1'b0, 16'h0, 1);
        issue(1, 16'h0110, 1'b0, 16'h0, 1);
        run_all("t6", 40);
        check_eq("t6_count", grant_log.size(), 2);
        check_eq("t6_first", grant_log[0], 0);
        check_eq("t6_second", grant_log[1], 1);

        check_eq("no_spurious_ready", spurious, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
